// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants, FSM state encoding and a modular-add helper.
package dilithium_pkg;

   localparam logic [22:0] Q      = 23'd8380417;
   localparam int          N_COEF = 256;
   localparam int          COEF_W = 23;
   localparam int          PROD_W = 46;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      DONE  = 3'd3
   } state_t;

   // (x + y) mod Q for x, y < Q: one conditional subtract is enough
   function automatic logic [COEF_W-1:0] mod_add(input logic [COEF_W-1:0] x,
                                                 input logic [COEF_W-1:0] y);
      logic [COEF_W:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= {1'b0, Q}) s = s - {1'b0, Q};
      return s[COEF_W-1:0];
   endfunction

endpackage

// File: rtl/pw_mul_pipe.sv
// Datapath of the pointwise multiplier: product register, address delay
// line and valid shift register. The FSM only tells it when a read issues.
// Optional accumulate stage under POINTWISE_ACC_EN.
module pw_mul_pipe
   import dilithium_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 24
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic [DATA_W-1:0] b_data,
`ifdef POINTWISE_ACC_EN
   input  logic              acc_en,
   input  logic [DATA_W-1:0] c_rd_data,
   output logic [ADDR_W-1:0] c_rd_addr,
`endif
   input  logic [COEF_W-1:0] reduction_output,
   output logic [PROD_W-1:0] reduction_input,
   output logic [ADDR_W-1:0] c_addr,
   output logic [DATA_W-1:0] c_data,
   output logic              c_web
);

`ifdef POINTWISE_ACC_EN
   localparam int STAGES = 3;
`else
   localparam int STAGES = 2;
`endif

   logic [STAGES:1]   vld_r;
   logic [STAGES:0]   vld_pipe;
   logic [ADDR_W-1:0] addr_r [1:STAGES];
   logic [PROD_W-1:0] prod_r;
   logic              unused_msb;

   // stage 0 is the read issued this cycle; stage 1 is RAM data on the bus
   assign vld_pipe   = {vld_r, issue};
   assign unused_msb = a_data[DATA_W-1] ^ b_data[DATA_W-1];

   // valid bits and the coefficient index travel together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_r <= '0;
         for (int i = 1; i <= STAGES; i++) addr_r[i] <= '0;
      end else begin
         vld_r     <= vld_pipe[STAGES-1:0];
         addr_r[1] <= rd_addr;
         for (int i = 2; i <= STAGES; i++) addr_r[i] <= addr_r[i-1];
      end
   end

   // full-width 23x23 product of the returned coefficients (bit 23 dropped)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         prod_r <= '0;
      else if (vld_pipe[1])
         prod_r <= PROD_W'(a_data[COEF_W-1:0]) * PROD_W'(b_data[COEF_W-1:0]);
   end

   assign reduction_input = prod_r;

`ifdef POINTWISE_ACC_EN
   logic [COEF_W-1:0] acc_r;
   logic              unused_c_msb;

   assign c_rd_addr    = addr_r[1];
   assign unused_c_msb = c_rd_data[DATA_W-1];

   // old C value arrives alongside the reduced product; add mod Q
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc_r <= '0;
      else if (vld_pipe[2])
         acc_r <= mod_add(c_rd_data[COEF_W-1:0], reduction_output);
   end

   // write port: stage 3 in accumulate mode, stage 2 otherwise
   always_comb begin
      c_web  = 1'b1;
      c_addr = addr_r[2];
      c_data = '0;
      if (acc_en) begin
         c_addr = addr_r[3];
         c_web  = ~vld_pipe[3];
         if (vld_pipe[3]) c_data = {{(DATA_W-COEF_W){1'b0}}, acc_r};
      end else begin
         c_web = ~vld_pipe[2];
         if (vld_pipe[2]) c_data = {{(DATA_W-COEF_W){1'b0}}, reduction_output};
      end
   end
`else
   // write port: reduced product lands in the same cycle it is presented
   always_comb begin
      c_addr = addr_r[2];
      c_web  = ~vld_pipe[2];
      c_data = '0;
      if (vld_pipe[2]) c_data = {{(DATA_W-COEF_W){1'b0}}, reduction_output};
   end
`endif

endmodule

// File: rtl/poly_pointwise_mul.sv
// c[k] = a[k]*b[k] mod Q over one NTT-domain polynomial, one coefficient
// per cycle. Reduction is done by the shared external unit.
// Optional accumulate mode (c = c_old + a*b mod Q) under POINTWISE_ACC_EN.
module poly_pointwise_mul
   import dilithium_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 24
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_mul,
`ifdef POINTWISE_ACC_EN
   input  logic              acc_mode,
   input  logic [DATA_W-1:0] c_rd_data,
   output logic [ADDR_W-1:0] c_rd_addr,
`endif
   output logic              busy,
   output logic              done_mul,
   output logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic [ADDR_W-1:0] c_addr,
   output logic [DATA_W-1:0] c_data,
   output logic              c_web,
   output logic [PROD_W-1:0] reduction_input,
   input  logic [COEF_W-1:0] reduction_output
);

   state_t     state, state_nx;
   logic [8:0] rd_cnt;
   logic [1:0] drn_cnt;
   logic       accept, rd_last, drn_last;

   // a start landing on the done pulse is dropped
   assign accept  = (state == IDLE) && start_mul && !done_mul;
   assign rd_last = (rd_cnt == 9'(N_COEF-1));
   assign busy    = (state != IDLE);
   assign a_addr  = ADDR_W'(rd_cnt);
   assign b_addr  = ADDR_W'(rd_cnt);

`ifdef POINTWISE_ACC_EN
   logic acc_q;

   // accumulate mode is fixed for the whole run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      acc_q <= 1'b0;
      else if (accept) acc_q <= acc_mode;
   end

   // drain covers the extra accumulate stage
   assign drn_last = (drn_cnt == (acc_q ? 2'd2 : 2'd1));
`else
   assign drn_last = (drn_cnt == 2'd1);
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept)   state_nx = RUN;
         RUN:     if (rd_last)  state_nx = DRAIN;
         DRAIN:   if (drn_last) state_nx = DONE;
         DONE:                  state_nx = IDLE;
         default:               state_nx = IDLE;
      endcase
   end

   // read counter: single pass, parks on the last address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_cnt <= '0;
      else if (accept)
         rd_cnt <= '0;
      else if (state == RUN && !rd_last)
         rd_cnt <= rd_cnt + 9'd1;
   end

   // drain length counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              drn_cnt <= '0;
      else if (state == DRAIN) drn_cnt <= drn_cnt + 2'd1;
      else                     drn_cnt <= '0;
   end

   // registered completion pulse, one cycle after DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) done_mul <= 1'b0;
      else        done_mul <= (state == DONE);
   end

   pw_mul_pipe #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pipe (
      .clk              (clk),
      .rst_n            (rst_n),
      .issue            (state == RUN),
      .rd_addr          (a_addr),
      .a_data           (a_data),
      .b_data           (b_data),
`ifdef POINTWISE_ACC_EN
      .acc_en           (acc_q),
      .c_rd_data        (c_rd_data),
      .c_rd_addr        (c_rd_addr),
`endif
      .reduction_output (reduction_output),
      .reduction_input  (reduction_input),
      .c_addr           (c_addr),
      .c_data           (c_data),
      .c_web            (c_web)
   );

endmodule

// File: tb/tb_poly_pointwise_mul.sv
// Scoreboard bench for poly_pointwise_mul: expected writes are queued when a
// run is loaded, a monitor pops and compares on every C write.
module tb_poly_pointwise_mul;

   localparam int          ADDR_W = 16;
   localparam int          DATA_W = 24;
   localparam logic [22:0] QV     = 23'd8380417;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [45:0]       red;
      bit                chk_red;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start_mul = 1'b0;
   logic              busy, done_mul;
   logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
   logic [DATA_W-1:0] a_data, b_data, c_data;
   logic              c_web;
   logic [45:0]       reduction_input;
   logic [22:0]       reduction_output;
`ifdef POINTWISE_ACC_EN
   logic              acc_mode = 1'b0;
   logic [DATA_W-1:0] c_rd_data;
   logic [ADDR_W-1:0] c_rd_addr;
`endif

   logic [DATA_W-1:0] a_ram [256];
   logic [DATA_W-1:0] b_ram [256];
   logic [DATA_W-1:0] c_ram [256];

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0, errors = 0;
   int   cyc = 0, wr_cnt = 0, done_cnt = 0;

   poly_pointwise_mul #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_mul        (start_mul),
`ifdef POINTWISE_ACC_EN
      .acc_mode         (acc_mode),
      .c_rd_data        (c_rd_data),
      .c_rd_addr        (c_rd_addr),
`endif
      .busy             (busy),
      .done_mul         (done_mul),
      .a_addr           (a_addr),
      .a_data           (a_data),
      .b_addr           (b_addr),
      .b_data           (b_data),
      .c_addr           (c_addr),
      .c_data           (c_data),
      .c_web            (c_web),
      .reduction_input  (reduction_input),
      .reduction_output (reduction_output)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural reduction unit and RAMs with 1-cycle read latency
   assign reduction_output = 23'(reduction_input % 46'(QV));
   always @(posedge clk) begin
      a_data <= a_ram[a_addr[7:0]];
      b_data <= b_ram[b_addr[7:0]];
`ifdef POINTWISE_ACC_EN
      c_rd_data <= c_ram[c_rd_addr[7:0]];
`endif
      if (rst_n && !c_web) c_ram[c_addr[7:0]] <= c_data;
   end

   // monitor: every C write must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (done_mul) done_cnt++;
         if (!c_web) begin
            wr_cnt++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL write_unexpected: addr=%0d data=%0d, no write expected", c_addr, c_data);
            end else begin
               mon_e = sb.pop_front();
               if (c_addr !== mon_e.addr || c_data !== mon_e.data ||
                   (mon_e.chk_red && reduction_input !== mon_e.red)) begin
                  errors++;
                  $display("FAIL write: got addr=%0d data=%0d red_in=%0d, expected addr=%0d data=%0d red_in=%0d",
                           c_addr, c_data, reduction_input, mon_e.addr, mon_e.data, mon_e.red);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic push(input int k, input logic [22:0] d, input logic [45:0] red, input bit cr);
      exp_t e;
      e.addr = ADDR_W'(k);
      e.data = {1'b0, d};
      e.red = red;
      e.chk_red = cr;
      sb.push_back(e);
   endtask

   // fill A/B for one run and queue the expected writes
   task automatic load(input int mode);
      logic [22:0] a, b;
      for (int k = 0; k < 256; k++) begin
         case (mode)
            0: begin  // identity: c = k
               a_ram[k] = 24'(k); b_ram[k] = 24'd1;
               push(k, 23'(k), 46'(k), 1'b1);
            end
            1: begin  // (Q-1)^2 = 2^46 - 2^37 + 2^26, == 1 mod Q
               a_ram[k] = 24'd8380416; b_ram[k] = 24'd8380416;
               push(k, 23'd1, 46'd70231372333056, 1'b1);
            end
            2: begin  // random operands below Q
               a = 23'($urandom_range(8380416, 0));
               b = 23'($urandom_range(8380416, 0));
               a_ram[k] = {1'b0, a}; b_ram[k] = {1'b0, b};
               push(k, 23'((64'(a) * 64'(b)) % 64'(QV)), 46'(64'(a) * 64'(b)), 1'b1);
            end
            3: begin  // bit 23 set on both inputs must be ignored: c = 3k
               a_ram[k] = 24'h800000 | 24'(k); b_ram[k] = 24'h800003;
               push(k, 23'(3 * k), 46'(3 * k), 1'b1);
            end
            default: begin  // c = 2k + 14
               a_ram[k] = 24'(k + 7); b_ram[k] = 24'd2;
               push(k, 23'(2 * k + 14), 46'(2 * k + 14), 1'b1);
            end
         endcase
      end
   endtask

   // one run: pulse start, wait for done (bounded), check latency and counts
   task automatic do_run(input string name, input int exp_lat);
      int  sc, w0;
      bit  seen;
      w0 = wr_cnt;
      @(negedge clk);
      start_mul = 1'b1;
      sc = cyc;
      @(negedge clk);
      start_mul = 1'b0;
      chk({name, "_busy_after_start"}, 64'(busy), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         #1;
         if (done_mul) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL %s_done_timeout: no done_mul within 400 cycles, expected one", name);
      end else begin
         chk({name, "_latency"}, 64'(cyc - sc + 1), 64'(exp_lat));
         chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
         chk({name, "_writes"}, 64'(wr_cnt - w0), 64'd256);
         chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, d0, sc;
      for (int k = 0; k < 256; k++) begin
         a_ram[k] = '0; b_ram[k] = '0; c_ram[k] = '0;
      end

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done_mul), 64'd0);
      chk("rst_c_web", 64'(c_web), 64'd1);
      chk("rst_a_addr", 64'(a_addr), 64'd0);
      chk("rst_c_addr", 64'(c_addr), 64'd0);
      chk("rst_c_data", 64'(c_data), 64'd0);
      chk("rst_red_in", 64'(reduction_input), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // identity run with latency check
      load(0);
      do_run("ident", 261);
      chk("ident_c5", 64'(c_ram[5]), 64'd5);
      chk("ident_c255", 64'(c_ram[255]), 64'd255);

      // (Q-1)*(Q-1)
      load(1);
      do_run("qm1", 261);

      // three back-to-back random runs, start the cycle after done
      w0 = wr_cnt;
      for (int r = 0; r < 3; r++) begin
         load(2);
         do_run("rand", 261);
      end
      chk("rand_total_writes", 64'(wr_cnt - w0), 64'd768);

      // stray starts at run cycles 5, 100 and 260 (the done cycle)
      repeat (3) @(negedge clk);
      load(3);
      w0 = wr_cnt; d0 = done_cnt;
      @(negedge clk);
      start_mul = 1'b1;
      sc = cyc;
      for (int i = 1; i <= 270; i++) begin
         @(negedge clk);
         start_mul = (i == 5 || i == 100 || i == 260);
      end
      start_mul = 1'b0;
      @(negedge clk);
      chk("stray_done_count", 64'(done_cnt - d0), 64'd1);
      chk("stray_writes", 64'(wr_cnt - w0), 64'd256);
      chk("stray_busy", 64'(busy), 64'd0);
      chk("stray_sb_empty", 64'(sb.size()), 64'd0);

      // reset at RUN cycle 40
      load(4);
      @(negedge clk);
      start_mul = 1'b1;
      @(negedge clk);
      start_mul = 1'b0;
      repeat (40) @(posedge clk);
      #2;
      chk("midrst_write_active", 64'(c_web), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_c_web", 64'(c_web), 64'd1);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_a_addr", 64'(a_addr), 64'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      load(4);
      do_run("after_rst", 261);
      chk("after_rst_c0", 64'(c_ram[0]), 64'd14);

`ifdef POINTWISE_ACC_EN
      // accumulate: (Q-1)+1 wraps to 0, then 5+1 = 6; one extra drain cycle
      acc_mode = 1'b1;
      for (int k = 0; k < 256; k++) begin
         a_ram[k] = 24'd1; b_ram[k] = 24'd1; c_ram[k] = 24'd8380416;
         push(k, 23'd0, 46'd1, 1'b0);
      end
      do_run("acc_wrap", 262);
      for (int k = 0; k < 256; k++) begin
         c_ram[k] = 24'd5;
         push(k, 23'd6, 46'd1, 1'b0);
      end
      do_run("acc_add", 262);
      acc_mode = 1'b0;
`endif

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
